// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared memory port,
// ALU and PC/IR/result registers, with a sticky illegal-instruction trap and a retired count.
module multi_cycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_srst,
    input  logic [6:0]           i_operand,
    input  logic [2:0]           i_funct3,
    input  logic                 i_funct7bit5,
    input  logic                 i_zero,
    input  logic                 i_memReady,
    output logic                 o_pcWrite,
    output logic                 o_adrSrc,
    output logic                 o_irWrite,
    output logic                 o_memWrite,
    output logic                 o_regWrite,
    output logic [1:0]           o_resultSrc,
    output logic [1:0]           o_aluSrcA,
    output logic [1:0]           o_aluSrcB,
    output logic [3:0]           o_aluLogicOperation,
    output logic                 o_illegal,
    output logic [INSTRET_W-1:0] o_instret,
    output logic [3:0]           o_state
);
    // Handshake: i_memReady high in FETCH, MEMREAD or MEMWRITE completes that access on
    // the rising edge; the FSM holds its state (and memWrite) every cycle it stays low.

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;
    logic   f3_ok;
    logic   retire;

    // Only ADD/SUB, SLT, XOR, OR and AND are implemented; shifts and SLTU trap.
    assign f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b010) || (i_funct3 == 3'b100) ||
                   (i_funct3 == 3'b110) || (i_funct3 == 3'b111);

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (i_memReady) state_next = S_DECODE;
            S_DECODE: begin
                case (i_operand)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:   state_next = (!f3_ok || (i_funct7bit5 && i_funct3 != 3'b000))
                                         ? S_TRAP : S_EXECUTER;
                    OP_I:   state_next = f3_ok ? S_EXECUTEI : S_TRAP;
                    OP_BEQ: state_next = S_BEQ;
                    OP_JAL: state_next = S_JAL;
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (i_operand == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (i_memReady) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (i_memReady) state_next = S_FETCH;
            S_EXECUTER, S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // JAL is not listed here: it retires through its ALUWB write-back.
    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                    ((state == S_MEMWRITE) && i_memReady);

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state     <= S_FETCH;
            o_instret <= '0;
            o_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (retire) o_instret <= o_instret + INSTRET_ONE;
            if (state_next == S_TRAP) o_illegal <= 1'b1;
        end
    end

    always_comb begin
        o_pcWrite           = 1'b0;
        o_adrSrc            = 1'b0;
        o_irWrite           = 1'b0;
        o_memWrite          = 1'b0;
        o_regWrite          = 1'b0;
        o_resultSrc         = 2'b00;
        o_aluSrcA           = 2'b00;
        o_aluSrcB           = 2'b00;
        o_aluLogicOperation = ALU_ADD;
        case (state)
            S_FETCH: begin
                o_aluSrcB   = 2'b10;
                o_resultSrc = 2'b10;
                o_irWrite   = i_memReady;
                o_pcWrite   = i_memReady;
            end
            S_DECODE: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b01;
            end
            S_MEMADR: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = 2'b01;
            end
            S_MEMREAD:  o_adrSrc = 1'b1;
            S_MEMWB: begin
                o_resultSrc = 2'b01;
                o_regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                o_adrSrc   = 1'b1;
                o_memWrite = 1'b1;
            end
            S_EXECUTER, S_EXECUTEI: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = (state == S_EXECUTEI) ? 2'b01 : 2'b00;
                case (i_funct3)
                    3'b000: o_aluLogicOperation = (state == S_EXECUTER && i_funct7bit5)
                                                  ? ALU_SUB : ALU_ADD;
                    3'b010: o_aluLogicOperation = ALU_SLT;
                    3'b100: o_aluLogicOperation = ALU_XOR;
                    3'b110: o_aluLogicOperation = ALU_OR;
                    3'b111: o_aluLogicOperation = ALU_AND;
                    default: o_aluLogicOperation = ALU_ADD;
                endcase
            end
            S_ALUWB:    o_regWrite = 1'b1;
            S_BEQ: begin
                o_aluSrcA           = 2'b10;
                o_aluLogicOperation = ALU_SUB;
                o_pcWrite           = i_zero;
            end
            S_JAL: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b10;
                o_pcWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides every write enable, even mid-transaction.
        if (i_srst) begin
            o_pcWrite  = 1'b0;
            o_irWrite  = 1'b0;
            o_memWrite = 1'b0;
            o_regWrite = 1'b0;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: steps each instruction class cycle by cycle
// against hand-computed control words, state sequence and retired count.
module tb_multi_cycle_controller;
    localparam int IW = 4;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BEQ      = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic          clk;
    logic          srst;
    logic [6:0]    operand;
    logic [2:0]    funct3;
    logic          funct7bit5;
    logic          zero;
    logic          mem_ready;
    logic          pc_write;
    logic          adr_src;
    logic          ir_write;
    logic          mem_write;
    logic          reg_write;
    logic [1:0]    result_src;
    logic [1:0]    alu_src_a;
    logic [1:0]    alu_src_b;
    logic [3:0]    alu_op;
    logic          illegal;
    logic [IW-1:0] instret;
    logic [3:0]    state;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    multi_cycle_controller #(.INSTRET_W(IW)) dut (
        .i_clk               (clk),
        .i_srst              (srst),
        .i_operand           (operand),
        .i_funct3            (funct3),
        .i_funct7bit5        (funct7bit5),
        .i_zero              (zero),
        .i_memReady          (mem_ready),
        .o_pcWrite           (pc_write),
        .o_adrSrc            (adr_src),
        .o_irWrite           (ir_write),
        .o_memWrite          (mem_write),
        .o_regWrite          (reg_write),
        .o_resultSrc         (result_src),
        .o_aluSrcA           (alu_src_a),
        .o_aluSrcB           (alu_src_b),
        .o_aluLogicOperation (alu_op),
        .o_illegal           (illegal),
        .o_instret           (instret),
        .o_state             (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard over the state trace: one expected state per cycle.
    task automatic run_trace(input string tag);
        while (exp_q.size() > 0) begin
            chk(tag, {28'd0, state}, {28'd0, exp_q.pop_front()});
            tick();
        end
    endtask

    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input logic [3:0] exec_st,
                           input logic [3:0] exp_op, input logic [1:0] exp_b,
                           input logic [IW-1:0] exp_inst);
        operand = op; funct3 = f3; funct7bit5 = f75; mem_ready = 1'b1;
        #1;
        chk({tag, "_fetch"}, state, ST_FETCH);
        tick();
        chk({tag, "_decode"}, state, ST_DECODE);
        tick();
        chk({tag, "_exec_state"}, state, exec_st);
        chk({tag, "_aluop"}, alu_op, exp_op);
        chk({tag, "_srca"}, alu_src_a, 2'b10);
        chk({tag, "_srcb"}, alu_src_b, exp_b);
        chk({tag, "_exec_regwrite"}, reg_write, 1'b0);
        tick();
        chk({tag, "_wb_state"}, state, ST_ALUWB);
        chk({tag, "_wb_regwrite"}, reg_write, 1'b1);
        chk({tag, "_wb_result"}, result_src, 2'b00);
        tick();
        chk({tag, "_done_state"}, state, ST_FETCH);
        chk({tag, "_instret"}, instret, exp_inst);
    endtask

    task automatic run_beq(input string tag, input logic z, input logic exp_pc,
                           input logic [IW-1:0] exp_inst);
        operand = OP_BEQ; zero = z; mem_ready = 1'b1;
        #1;
        chk({tag, "_fetch"}, state, ST_FETCH);
        tick();
        chk({tag, "_decode_pcwrite"}, pc_write, 1'b0);
        tick();
        chk({tag, "_state"}, state, ST_BEQ);
        chk({tag, "_pcwrite"}, pc_write, exp_pc);
        chk({tag, "_aluop"}, alu_op, 4'd1);
        chk({tag, "_srca"}, alu_src_a, 2'b10);
        chk({tag, "_srcb"}, alu_src_b, 2'b00);
        tick();
        chk({tag, "_done_state"}, state, ST_FETCH);
        chk({tag, "_instret"}, instret, exp_inst);
    endtask

    task automatic run_trap(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic f75);
        operand = op; funct3 = f3; funct7bit5 = f75; mem_ready = 1'b1; zero = 1'b0;
        #1;
        tick();
        chk({tag, "_decode"}, state, ST_DECODE);
        tick();
        chk({tag, "_state"}, state, ST_TRAP);
        chk({tag, "_illegal"}, illegal, 1'b1);
        zero = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk({tag, "_hold_state"}, state, ST_TRAP);
            chk({tag, "_hold_illegal"}, illegal, 1'b1);
            chk({tag, "_hold_enables"}, {pc_write, ir_write, mem_write, reg_write}, 4'b0000);
        end
        srst = 1'b1;
        tick();
        chk({tag, "_clr_state"}, state, ST_FETCH);
        chk({tag, "_clr_illegal"}, illegal, 1'b0);
        srst = 1'b0;
        zero = 1'b0;
    endtask

    // Directed stimulus
    initial begin
        srst = 1'b1; operand = OP_SW; funct3 = 3'b010; funct7bit5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        chk("reset_state", state, ST_FETCH);
        chk("reset_instret", instret, 4'd0);
        chk("reset_illegal", illegal, 1'b0);
        mem_ready = 1'b1;
        #1;
        chk("reset_irwrite_forced", ir_write, 1'b0);
        chk("reset_pcwrite_forced", pc_write, 1'b0);

        // sw, no stalls: 4 cycles
        srst = 1'b0;
        #1;
        chk("fetch_irwrite", ir_write, 1'b1);
        chk("fetch_pcwrite", pc_write, 1'b1);
        chk("fetch_adrsrc", adr_src, 1'b0);
        chk("fetch_srcb", alu_src_b, 2'b10);
        chk("fetch_result", result_src, 2'b10);
        chk("fetch_aluop", alu_op, 4'd0);
        tick();
        chk("sw_decode", state, ST_DECODE);
        chk("sw_decode_srca", alu_src_a, 2'b01);
        chk("sw_decode_srcb", alu_src_b, 2'b01);
        chk("sw_decode_irwrite", ir_write, 1'b0);
        tick();
        chk("sw_memadr", state, ST_MEMADR);
        chk("sw_memadr_srca", alu_src_a, 2'b10);
        chk("sw_memadr_srcb", alu_src_b, 2'b01);
        tick();
        chk("sw_memwrite_state", state, ST_MEMWRITE);
        chk("sw_memwrite", mem_write, 1'b1);
        chk("sw_adrsrc", adr_src, 1'b1);
        chk("sw_instret_before", instret, 4'd0);
        tick();
        chk("sw_done", state, ST_FETCH);
        chk("sw_done_memwrite", mem_write, 1'b0);
        chk("sw_instret", instret, 4'd1);

        // sw stalled in MEMWRITE, then reset mid-operation
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("stall_memwrite_state", state, ST_MEMWRITE);
        chk("stall_memwrite_1", mem_write, 1'b1);
        tick();
        chk("stall_memwrite_state2", state, ST_MEMWRITE);
        chk("stall_memwrite_2", mem_write, 1'b1);
        chk("stall_no_retire", instret, 4'd1);
        srst = 1'b1;
        #1;
        chk("midrst_memwrite_forced", mem_write, 1'b0);
        tick();
        chk("midrst_state", state, ST_FETCH);
        chk("midrst_memwrite", mem_write, 1'b0);
        chk("midrst_instret", instret, 4'd0);
        srst = 1'b0;

        // lw: FETCH stall first, then MEMREAD low for 2 cycles -> MEMWB at cycle 7
        operand = OP_LW;
        #1;
        chk("fetch_stall_irwrite", ir_write, 1'b0);
        chk("fetch_stall_pcwrite", pc_write, 1'b0);
        tick();
        chk("fetch_stall_state", state, ST_FETCH);
        mem_ready = 1'b1;
        tick();
        tick();
        chk("lw_memadr", state, ST_MEMADR);
        mem_ready = 1'b0;
        tick();
        chk("lw_memread_c4", state, ST_MEMREAD);
        chk("lw_memread_adrsrc", adr_src, 1'b1);
        chk("lw_memread_regwrite", reg_write, 1'b0);
        tick();
        chk("lw_memread_c5", state, ST_MEMREAD);
        tick();
        chk("lw_memread_c6", state, ST_MEMREAD);
        mem_ready = 1'b1;
        tick();
        chk("lw_memwb_c7", state, ST_MEMWB);
        chk("lw_memwb_regwrite", reg_write, 1'b1);
        chk("lw_memwb_result", result_src, 2'b01);
        chk("lw_memwb_instret", instret, 4'd0);
        tick();
        chk("lw_done", state, ST_FETCH);
        chk("lw_done_regwrite", reg_write, 1'b0);
        chk("lw_instret", instret, 4'd1);

        // ALU class: funct3 decode and SUB only for R with IR[30]
        run_alu("r_sub",  OP_R, 3'b000, 1'b1, ST_EXECUTER, 4'd1, 2'b00, 4'd2);
        run_alu("r_add",  OP_R, 3'b000, 1'b0, ST_EXECUTER, 4'd0, 2'b00, 4'd3);
        run_alu("i_addi", OP_I, 3'b000, 1'b1, ST_EXECUTEI, 4'd0, 2'b01, 4'd4);
        run_alu("r_xor",  OP_R, 3'b100, 1'b0, ST_EXECUTER, 4'd4, 2'b00, 4'd5);
        run_alu("r_and",  OP_R, 3'b111, 1'b0, ST_EXECUTER, 4'd2, 2'b00, 4'd6);
        run_alu("i_ori",  OP_I, 3'b110, 1'b0, ST_EXECUTEI, 4'd3, 2'b01, 4'd7);
        run_alu("i_slti", OP_I, 3'b010, 1'b1, ST_EXECUTEI, 4'd5, 2'b01, 4'd8);

        run_beq("beq_taken",    1'b1, 1'b1, 4'd9);
        run_beq("beq_nottaken", 1'b0, 1'b0, 4'd10);

        // jal: pcWrite in JAL, rd write in ALUWB, one retirement
        operand = OP_JAL;
        tick();
        tick();
        chk("jal_state", state, ST_JAL);
        chk("jal_pcwrite", pc_write, 1'b1);
        chk("jal_srca", alu_src_a, 2'b01);
        chk("jal_srcb", alu_src_b, 2'b10);
        chk("jal_regwrite", reg_write, 1'b0);
        chk("jal_instret_mid", instret, 4'd10);
        tick();
        chk("jal_wb_state", state, ST_ALUWB);
        chk("jal_wb_regwrite", reg_write, 1'b1);
        chk("jal_wb_pcwrite", pc_write, 1'b0);
        tick();
        chk("jal_done", state, ST_FETCH);
        chk("jal_instret", instret, 4'd11);

        // Counter wrap: five more beqs take 11 -> 16 mod 16 = 0
        operand = OP_BEQ;
        zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ST_FETCH);
            exp_q.push_back(ST_DECODE);
            exp_q.push_back(ST_BEQ);
            run_trace("wrap_trace");
            chk("wrap_instret", instret, (12 + i) % 16);
        end
        zero = 1'b0;

        run_trap("trap_lui",     OP_LUI, 3'b000, 1'b0);
        run_trap("trap_r_sll",   OP_R,   3'b001, 1'b0);
        run_trap("trap_r_f7xor", OP_R,   3'b100, 1'b1);
        run_trap("trap_i_srli",  OP_I,   3'b101, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core; replaces the single-cycle combinational controller.
- Sequences one shared memory port, one ALU and the PC/IR/result registers over 3-5 cycles per instruction.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Adds a memory ready handshake, sticky illegal-instruction trap and a retired-instruction counter.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_srst  in  1  synchronous active-high reset.
- i_operand  in  7  opcode from instruction register (IR[6:0]).
- i_funct3  in  3  IR[14:12].
- i_funct7bit5  in  1  IR[30].
- i_zero  in  1  ALU result == 0.
- i_memReady  in  1  memory access completes this cycle.
- o_pcWrite  out  1  load PC from result bus.
- o_adrSrc  out  1  memory address: 0=PC, 1=ALUOut.
- o_irWrite  out  1  load IR and oldPC from memory read data.
- o_memWrite  out  1  memory write strobe.
- o_regWrite  out  1  register file write enable.
- o_resultSrc  out  2  result bus: 00=ALUOut, 01=memory data, 10=ALU result.
- o_aluSrcA  out  2  ALU A: 00=PC, 01=oldPC, 10=rs1.
- o_aluSrcB  out  2  ALU B: 00=rs2, 01=immExt, 10=constant 4.
- o_aluLogicOperation  out  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5.
- o_illegal  out  1  sticky trap flag.
- o_instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Reset: while i_srst=1, next state is FETCH, o_instret=0 and o_illegal=0.
- Reset: while i_srst=1, o_pcWrite, o_irWrite, o_memWrite and o_regWrite are forced to 0. Reset wins over every other event.
- Outputs are decoded from the current state (Moore), except the i_memReady / i_zero gating noted below.
- Any output not listed for a state is 0.
- FETCH:
  - Drives adrSrc=0, aluSrcA=00, aluSrcB=10, ADD, resultSrc=10.
  - irWrite=i_memReady, pcWrite=i_memReady.
  - Stays in FETCH until i_memReady, then goes to DECODE.
- DECODE (branch-target precompute):
  - Drives aluSrcA=01, aluSrcB=01, ADD.
  - lw/sw -> MEMADR; R -> EXECUTER; I-ALU -> EXECUTEI; beq -> BEQ; jal -> JAL.
  - Any other opcode, or unsupported funct3 on R/I (001, 011, 101), or funct7bit5=1 with funct3!=000 on R -> TRAP.
- MEMADR: drives aluSrcA=10, aluSrcB=01, ADD. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: drives adrSrc=1, resultSrc=00. Waits for i_memReady, then -> MEMWB.
- MEMWB: drives resultSrc=01, regWrite=1 -> FETCH.
- MEMWRITE:
  - Drives adrSrc=1, resultSrc=00, memWrite=1.
  - memWrite is held every cycle until i_memReady, then -> FETCH.
- EXECUTER: drives aluSrcA=10, aluSrcB=00 -> ALUWB.
- EXECUTEI: drives aluSrcA=10, aluSrcB=01 -> ALUWB.
- ALU operation in EXECUTER/EXECUTEI, by funct3:
  - 000: ADD, or SUB only in R with funct7bit5=1.
  - 010: SLT. 100: XOR. 110: OR. 111: AND.
- ALUWB: drives resultSrc=00, regWrite=1 -> FETCH.
- BEQ: drives aluSrcA=10, aluSrcB=00, SUB, resultSrc=00, pcWrite=i_zero -> FETCH.
- JAL: drives aluSrcA=01, aluSrcB=10, ADD, resultSrc=00, pcWrite=1 -> ALUWB (rd <= oldPC+4).
- TRAP:
  - o_illegal=1, all enables 0.
  - Stays in TRAP until reset.
- o_instret increments by 1 on each retirement, i.e. the cycle leaving MEMWB, ALUWB or BEQ, or MEMWRITE with i_memReady=1.
- JAL retires once, via ALUWB.
- o_instret wraps modulo 2^INSTRET_W.
- Latency (cycles, with i_memReady=1 every cycle): lw 5, sw 4, R/I 4, beq 3, jal 4.
- Each cycle i_memReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- i_memReady is ignored in all other states.

Test Plan:
- Reset mid-operation: enter MEMWRITE, hold i_memReady=0 for 2 cycles, assert i_srst -> next cycle state FETCH, o_memWrite=0, o_instret=0.
- lw with i_memReady low 2 cycles in MEMREAD -> regWrite pulses once with resultSrc=01 at cycle 7 after FETCH; o_instret=1.
- R-type sub (funct3=000, funct7bit5=1), then R-type add, then I-type addi with funct7bit5=1 (i.e. IR[30]=1 in the immediate):
  - sub -> aluLogicOperation=1 in EXECUTER.
  - add -> 0 in EXECUTER.
  - addi -> 0 (ADD, not SUB) in EXECUTEI.
  - Each instruction takes 4 cycles.
- beq with i_zero=1 -> pcWrite=1 in BEQ. With i_zero=0 -> pcWrite=0. Both take 3 cycles and both increment o_instret.
- jal -> pcWrite=1 in JAL, then regWrite=1 in ALUWB; o_instret increments by exactly 1.
- Opcode 0110111, then R-type funct3=001 (separately):
  - Each -> TRAP after DECODE; o_illegal=1 persists for 10+ cycles.
  - No enables asserted while in TRAP.
  - Cleared only by i_srst.
